// File: rtl/edge_zbt_writer_pkg.sv
// edge_zbt_writer_pkg: shared widths, 6:6:6 pixel reduction and packing FSM encoding
package edge_zbt_writer_pkg;
    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int PIX18_W    = 18;

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} pack_state_e;

    function automatic logic [PIX18_W-1:0] reduce_666(input logic [23:0] pix);
        return {pix[23:18], pix[15:10], pix[7:2]};
    endfunction
endpackage

// File: rtl/edge_wr_fifo.sv
// edge_wr_fifo: DEPTH-entry synchronous FIFO; a push alongside a pop is accepted even when full
module edge_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 55
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 din_i,
    output logic [W-1:0]                 dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din_i;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/edge_zbt_writer.sv
// edge_zbt_writer: packs 6:6:6 pixel pairs into 36-bit ZBT words, queues them and
// issues them into arbiter-granted write slots with WR_LAT-delayed write data.
module edge_zbt_writer
    import edge_zbt_writer_pkg::*;
#(
    parameter int ADDR_W = ZBT_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int WR_LAT = 2,
    parameter int HBITS  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pix_valid_i,
    input  logic [23:0]           pix_i,
    input  logic [10:0]           hcount_i,
    input  logic [9:0]            vcount_i,
    input  logic                  wr_grant_i,
    output logic                  wr_req_o,
    output logic [ADDR_W-1:0]     zbt_addr_o,
    output logic                  zbt_we_o,
    output logic [ZBT_DATA_W-1:0] zbt_wdata_o,
    output logic                  overflow_o
);
    localparam int EW = ADDR_W + ZBT_DATA_W;

    pack_state_e               state_q, state_d;
    logic [PIX18_W-1:0]        hi_q, hi_d, p18;
    logic [ADDR_W-1:0]         base_q, base_d, pix_addr;
    logic                      push_q, push_d;
    logic [EW-1:0]             word_q, word_d, head;
    logic                      full, empty, pop, overflow_q;
    logic [$clog2(DEPTH+1)-1:0] unused_count;
    logic                      unused_vcount;
    logic [ZBT_DATA_W-1:0]     pipe_q [WR_LAT];
    logic [WR_LAT-1:0]         vld_q;
    logic [ZBT_DATA_W-1:0]     hold_q;

    assign p18           = reduce_666(pix_i);
    assign pix_addr      = {vcount_i[ADDR_W-HBITS-1:0], hcount_i[HBITS:1]};
    assign unused_vcount = ^vcount_i;

    // An even pixel always (re)starts a pair; an odd one completes it only if it matches the held column pair.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        base_d  = base_q;
        push_d  = 1'b0;
        word_d  = word_q;
        if (pix_valid_i && !hcount_i[0]) begin
            hi_d    = p18;
            base_d  = pix_addr;
            state_d = ODD;
        end else if (pix_valid_i && state_q == ODD && base_q[HBITS-1:0] == hcount_i[HBITS:1]) begin
            push_d  = 1'b1;
            word_d  = {base_q, hi_q, p18};
            state_d = EVEN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EVEN;
            hi_q    <= '0;
            base_q  <= '0;
            push_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            base_q  <= base_d;
            push_q  <= push_d;
            word_q  <= word_d;
        end
    end

    edge_wr_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_q),
        .pop_i   (pop),
        .din_i   (word_q),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (unused_count)
    );

    assign wr_req_o   = !empty;
    assign pop        = wr_req_o && wr_grant_i;
    assign zbt_we_o   = pop;
    assign zbt_addr_o = pop ? head[EW-1:ZBT_DATA_W] : '0;
    assign overflow_o = overflow_q;
    assign zbt_wdata_o = vld_q[WR_LAT-1] ? pipe_q[WR_LAT-1] : hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WR_LAT; i++) pipe_q[i] <= '0;
            vld_q      <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pipe_q[0] <= head[ZBT_DATA_W-1:0];
            vld_q[0]  <= pop;
            for (int i = 1; i < WR_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
            if (vld_q[WR_LAT-1]) hold_q <= pipe_q[WR_LAT-1];
            if (push_q && full && !pop) overflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_edge_zbt_writer.sv
// tb_edge_zbt_writer: directed scenarios for the ZBT write packer with hand-computed expectations
module tb_edge_zbt_writer;
    logic        clk = 1'b0, rst_n = 1'b1, pix_valid = 1'b0, wr_grant = 1'b0;
    logic [23:0] pix = '0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        wr_req, zbt_we, overflow;
    logic [18:0] zbt_addr;
    logic [35:0] zbt_wdata;
    int          n_checks = 0, n_fail = 0, cyc = 0;
    logic [18:0] wa[$];
    int          wc[$];
    logic [35:0] wd [0:4095];

    edge_zbt_writer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pix_valid_i (pix_valid),
        .pix_i       (pix),
        .hcount_i    (hcount),
        .vcount_i    (vcount),
        .wr_grant_i  (wr_grant),
        .wr_req_o    (wr_req),
        .zbt_addr_o  (zbt_addr),
        .zbt_we_o    (zbt_we),
        .zbt_wdata_o (zbt_wdata),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    // Log every write and the write-data bus once per cycle, mid-cycle.
    always @(negedge clk) begin
        wd[cyc] = zbt_wdata;
        if (zbt_we) begin
            wa.push_back(zbt_addr);
            wc.push_back(cyc);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [10:0] h, input logic [9:0] vc, input logic [23:0] p);
        pix_valid = v;
        hcount    = h;
        vcount    = vc;
        pix       = p;
        tick();
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        pix_valid = 1'b0;
        wr_grant  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wa.delete();
        wc.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'($urandom);
            wr_grant  = 1'($urandom);
            pix       = 24'($urandom);
            hcount    = 11'($urandom);
            vcount    = 10'($urandom);
            @(negedge clk);
            n_checks++;
            if ({wr_req, zbt_we, zbt_addr, zbt_wdata, overflow} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got req=%b we=%b addr=%h wdata=%h ovf=%b, need all 0",
                         i, wr_req, zbt_we, zbt_addr, zbt_wdata, overflow);
            end
            tick();
        end
        pix_valid = 1'b0;
        wr_grant  = 1'b0;
        rst_n     = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({wr_req, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got req=%b ovf=%b, need 0 0", wr_req, overflow);
        end
        tick();
        wa.delete();
        wc.delete();
    endtask

    task automatic test_pair_pack();
        wr_grant = 1'b1;
        drive(1'b1, 11'd4, 10'd3, 24'hFFFFFF);
        drive(1'b1, 11'd5, 10'd3, 24'h000000);
        idle(8);
        n_checks++;
        if (wa.size() != 1) begin
            n_fail++;
            $display("FAIL pair_count: got %0d writes, need 1", wa.size());
        end else begin
            n_checks += 3;
            if (wa[0] !== 19'h00C02) begin
                n_fail++;
                $display("FAIL pair_addr: got %h, need 00c02", wa[0]);
            end
            if (wd[wc[0]+2] !== 36'hFFFFC0000) begin
                n_fail++;
                $display("FAIL pair_data: got %h, need ffffc0000", wd[wc[0]+2]);
            end
            if (wd[wc[0]+1] !== 36'h0) begin
                n_fail++;
                $display("FAIL pair_latency: data early, got %h one cycle after we, need 0", wd[wc[0]+1]);
            end
        end
        wa.delete();
        wc.delete();
    endtask

    task automatic test_orphan();
        wr_grant = 1'b1;
        drive(1'b1, 11'd7,  10'd3, 24'h123456);
        drive(1'b1, 11'd8,  10'd3, 24'h123456);
        drive(1'b1, 11'd9,  10'd3, 24'hABCDEF);
        drive(1'b1, 11'd10, 10'd3, 24'hFFFFFF);
        drive(1'b1, 11'd12, 10'd3, 24'h000000);
        drive(1'b1, 11'd13, 10'd3, 24'hFFFFFF);
        idle(8);
        n_checks++;
        if (wa.size() != 2) begin
            n_fail++;
            $display("FAIL orphan_count: got %0d writes, need 2", wa.size());
        end else begin
            n_checks += 4;
            if (wa[0] !== 19'h00C04) begin
                n_fail++;
                $display("FAIL orphan_addr: got %h, need 00c04", wa[0]);
            end
            if (wd[wc[0]+2] !== 36'h10D56ACFB) begin
                n_fail++;
                $display("FAIL orphan_data: got %h, need 10d56acfb", wd[wc[0]+2]);
            end
            if (wa[1] !== 19'h00C06) begin
                n_fail++;
                $display("FAIL relatch_addr: got %h, need 00c06", wa[1]);
            end
            if (wd[wc[1]+2] !== 36'h00003FFFF) begin
                n_fail++;
                $display("FAIL relatch_data: got %h, need 00003ffff", wd[wc[1]+2]);
            end
        end
        wa.delete();
        wc.delete();
    endtask

    task automatic test_backpressure();
        wr_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 11'(2*i),   10'd1, 24'h000000);
            drive(1'b1, 11'(2*i+1), 10'd1, 24'(i*4));
        end
        idle(3);
        @(negedge clk);
        n_checks++;
        if ({wr_req, overflow, wa.size() == 0} !== 3'b111) begin
            n_fail++;
            $display("FAIL bp_stall: got req=%b ovf=%b writes=%0d, need 1 1 0", wr_req, overflow, wa.size());
        end
        tick();
        wr_grant = 1'b1;
        repeat (4) tick();
        wr_grant = 1'b0;
        idle(5);
        @(negedge clk);
        n_checks++;
        if (wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained: got req=%b, need 0", wr_req);
        end
        n_checks++;
        if (wa.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes, need 4", wa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks += 3;
                if (wa[k] !== 19'(19'h400 + k)) begin
                    n_fail++;
                    $display("FAIL bp_addr[%0d]: got %h, need %h", k, wa[k], 19'(19'h400 + k));
                end
                if (wc[k] != wc[0] + k) begin
                    n_fail++;
                    $display("FAIL bp_b2b[%0d]: got cycle %0d, need %0d", k, wc[k], wc[0] + k);
                end
                if (wd[wc[k]+2] !== 36'(k)) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: got %h, need %h", k, wd[wc[k]+2], 36'(k));
                end
            end
        end
        tick();
        wa.delete();
        wc.delete();
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 11'(2*i),   10'd2, 24'h000000);
            drive(1'b1, 11'(2*i+1), 10'd2, 24'(i*4));
            if (i == 3) idle(3);
        end
        pix_valid = 1'b0;
        wr_grant  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({zbt_we, zbt_addr} !== {1'b1, 19'h00800}) begin
            n_fail++;
            $display("FAIL fpp_pop: got we=%b addr=%h, need 1 00800", zbt_we, zbt_addr);
        end
        tick();
        wr_grant = 1'b0;
        idle(3);
        @(negedge clk);
        n_checks++;
        if ({wr_req, overflow} !== 2'b10) begin
            n_fail++;
            $display("FAIL fpp_state: got req=%b ovf=%b, need 1 0", wr_req, overflow);
        end
        tick();
        wr_grant = 1'b1;
        repeat (4) tick();
        wr_grant = 1'b0;
        idle(5);
        @(negedge clk);
        n_checks++;
        if ({wr_req, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL fpp_end: got req=%b ovf=%b, need 0 0", wr_req, overflow);
        end
        n_checks++;
        if (wa.size() != 5) begin
            n_fail++;
            $display("FAIL fpp_count: got %0d writes, need 5", wa.size());
        end else begin
            for (int k = 1; k < 5; k++) begin
                n_checks++;
                if (wa[k] !== 19'(19'h800 + k)) begin
                    n_fail++;
                    $display("FAIL fpp_addr[%0d]: got %h, need %h", k, wa[k], 19'(19'h800 + k));
                end
            end
            n_checks++;
            if (wd[wc[4]+2] !== 36'd4) begin
                n_fail++;
                $display("FAIL fpp_last_data: got %h, need 4", wd[wc[4]+2]);
            end
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic found;
        apply_reset();
        found    = 1'b0;
        wr_grant = 1'b1;
        drive(1'b1, 11'd4, 10'd3, 24'hFFFFFF);
        drive(1'b1, 11'd5, 10'd3, 24'h000000);
        pix_valid = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = zbt_we;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mr_we: got no write within 10 cycles, need one");
        end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({zbt_wdata, wr_req, overflow} !== '0) begin
            n_fail++;
            $display("FAIL mr_reset: got wdata=%h req=%b ovf=%b, need 0", zbt_wdata, wr_req, overflow);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 11'd5, 10'd3, 24'hFFFFFF);
        idle(8);
        @(negedge clk);
        n_checks++;
        if (zbt_wdata !== 36'h0 || wa.size() != 1) begin
            n_fail++;
            $display("FAIL mr_after: got wdata=%h writes=%0d, need 0 and 1", zbt_wdata, wa.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_pair_pack();
        test_orphan();
        test_backpressure();
        test_full_push_pop();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
